// File: rtl/mem_arbiter_rr.sv
// N-port round-robin arbiter in front of a single block-wide memory port.
// One transaction in flight; responses are routed back to the granted port, with optional timeout.
module mem_arbiter_rr #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BLK_SIZE  = 128,
  parameter int unsigned STRB_W    = BLK_SIZE / 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_PORTS-1:0]          req_valid_i,
  output logic [NUM_PORTS-1:0]          req_ready_o,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_PORTS*STRB_W-1:0]   req_wstrb_i,
  input  logic [NUM_PORTS*BLK_SIZE-1:0] req_wdata_i,
  output logic [NUM_PORTS-1:0]          res_valid_o,
  output logic                          res_err_o,
  output logic [BLK_SIZE-1:0]           res_data_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [STRB_W-1:0]             mem_wstrb_o,
  output logic [BLK_SIZE-1:0]           mem_wdata_o,
  input  logic                          mem_res_valid_i,
  input  logic [BLK_SIZE-1:0]           mem_rdata_i
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q;
  logic [PTR_W-1:0]      rr_ptr_q;
  logic [PTR_W-1:0]      owner_q;
  logic [CNT_W-1:0]      wait_cnt_q;
  logic [NUM_PORTS-1:0]  res_valid_q;
  logic                  res_err_q;
  logic [BLK_SIZE-1:0]   res_data_q;
  logic                  mem_req_valid_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [STRB_W-1:0]     mem_wstrb_q;
  logic [BLK_SIZE-1:0]   mem_wdata_q;

  logic                  grant_vld_c;
  logic [PTR_W-1:0]      grant_idx_c;
  logic [PTR_W:0]        cand_c;
  logic [NUM_PORTS-1:0]  grant_oh_c;
  logic [NUM_PORTS-1:0]  owner_oh_c;
  logic [ADDR_W-1:0]     sel_addr_c;
  logic [STRB_W-1:0]     sel_wstrb_c;
  logic [BLK_SIZE-1:0]   sel_wdata_c;

  // Rotating-priority search starting at rr_ptr_q, wrapped explicitly for any port count.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    cand_c      = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand_c = (PTR_W+1)'(rr_ptr_q) + (PTR_W+1)'(k);
      if (cand_c >= (PTR_W+1)'(NUM_PORTS)) begin
        cand_c = cand_c - (PTR_W+1)'(NUM_PORTS);
      end
      if (!grant_vld_c && req_valid_i[cand_c[PTR_W-1:0]]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = cand_c[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_addr_c  = '0;
    sel_wstrb_c = '0;
    sel_wdata_c = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx_c == PTR_W'(i)) begin
        sel_addr_c  = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_wstrb_c = req_wstrb_i[i*STRB_W +: STRB_W];
        sel_wdata_c = req_wdata_i[i*BLK_SIZE +: BLK_SIZE];
      end
    end
  end

  assign grant_oh_c = NUM_PORTS'(1) << grant_idx_c;
  assign owner_oh_c = NUM_PORTS'(1) << owner_q;

  // Accept is a same-cycle handshake; gated by reset so all outputs drop immediately.
  assign req_ready_o = (state_q == IDLE && grant_vld_c && !rst_i) ? grant_oh_c : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      owner_q         <= '0;
      wait_cnt_q      <= '0;
      res_valid_q     <= '0;
      res_err_q       <= 1'b0;
      res_data_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wstrb_q     <= '0;
      mem_wdata_q     <= '0;
    end else begin
      res_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant_vld_c) begin
            mem_addr_q      <= sel_addr_c;
            mem_wstrb_q     <= sel_wstrb_c;
            mem_wdata_q     <= sel_wdata_c;
            mem_req_valid_q <= 1'b1;
            owner_q         <= grant_idx_c;
            rr_ptr_q        <= (grant_idx_c == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx_c + 1'b1;
            state_q         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            wait_cnt_q      <= '0;
            state_q         <= RESP;
          end
        end
        RESP: begin
          // A response landing on the timeout cycle still wins.
          if (mem_res_valid_i) begin
            res_valid_q <= owner_oh_c;
            res_err_q   <= 1'b0;
            res_data_q  <= mem_rdata_i;
            state_q     <= IDLE;
          end else if (TIMEOUT != 0 && wait_cnt_q == CNT_W'(TIMEOUT)) begin
            res_valid_q <= owner_oh_c;
            res_err_q   <= 1'b1;
            res_data_q  <= '0;
            state_q     <= IDLE;
          end else if (wait_cnt_q != CNT_W'(TIMEOUT)) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid_o     = res_valid_q;
  assign res_err_o       = res_err_q;
  assign res_data_o      = res_data_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wstrb_o     = mem_wstrb_q;
  assign mem_wdata_o     = mem_wdata_q;

endmodule
